// File: rtl/md_scheduler.sv
// Multiply/divide sequencer: computes results at start, holds them pending for a fixed
// busy latency, then commits to the architectural HI/LO registers.
module md_scheduler #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  md_op,
   input  logic        ex_valid,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        read_hi,
   input  logic        id_md_use,
   output logic        busy,
   output logic        stall_req,
   output logic [31:0] HI,
   output logic [31:0] LO,
   output logic [31:0] md_out
);

   localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW         = $clog2(MAX_CYCLES + 1);

   typedef enum logic {IDLE, BUSY} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic          start, commit, is_div, wr_hi, wr_lo;
   logic [31:0]   p_hi, p_lo;
   logic          p_dz;

   logic [63:0]        prod_s, prod_u;
   logic signed [31:0] sa, sb_nz;
   logic [31:0]        ub_nz;
   logic signed [31:0] q_s, r_s;
   logic [31:0]        q_u, r_u;
   logic [31:0]        res_hi, res_lo;

   assign busy      = (state == BUSY);
   assign is_div    = (md_op == 3'd3) || (md_op == 3'd4);
   assign start     = ex_valid & ~busy & (md_op != 3'd0) & (md_op <= 3'd4);
   assign wr_hi     = ex_valid & ~busy & (md_op == 3'd5);
   assign wr_lo     = ex_valid & ~busy & (md_op == 3'd6);
   assign stall_req = id_md_use & (busy | start);
   assign md_out    = read_hi ? HI : LO;

   // Low 64 bits of a sign-extended 64x64 product equal the signed 32x32 product.
   assign prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
   assign prod_u = {32'd0, A} * {32'd0, B};

   // Divisor forced to 1 on zero only to keep the datapath X-free; the result is discarded.
   assign sa    = $signed(A);
   assign sb_nz = (B == '0) ? 32'sd1 : $signed(B);
   assign ub_nz = (B == '0) ? 32'd1 : B;
   assign q_s   = sa / sb_nz;
   assign r_s   = sa % sb_nz;
   assign q_u   = A / ub_nz;
   assign r_u   = A % ub_nz;

   always_comb begin
      res_hi = '0;
      res_lo = '0;
      case (md_op)
         3'd1:    {res_hi, res_lo} = prod_s;
         3'd2:    {res_hi, res_lo} = prod_u;
         3'd3:    begin res_hi = r_s; res_lo = q_s; end
         3'd4:    begin res_hi = r_u; res_lo = q_u; end
         default: begin res_hi = '0; res_lo = '0; end
      endcase
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      commit   = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nx = BUSY;
               cnt_nx   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
            end
         end
         BUSY: begin
            cnt_nx = cnt - CW'(1);
            if (cnt == CW'(1)) begin
               commit   = 1'b1;
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
         HI    <= '0;
         LO    <= '0;
         p_hi  <= '0;
         p_lo  <= '0;
         p_dz  <= 1'b0;
      end else begin
         state <= state_nx;
         cnt   <= cnt_nx;
         if (start) begin
            p_hi <= res_hi;
            p_lo <= res_lo;
            p_dz <= is_div & (B == '0);
         end
         if (commit) begin
            if (!p_dz) begin
               HI <= p_hi;
               LO <= p_lo;
            end
         end else begin
            if (wr_hi) HI <= A;
            if (wr_lo) LO <= B;
         end
      end
   end

endmodule

// File: tb/tb_md_scheduler.sv
// Directed self-checking bench for md_scheduler: mult/multu/div/divu, divide by zero,
// mthi/mtlo, stall timing and asynchronous reset mid-operation.
module tb_md_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  md_op;
   logic        ex_valid;
   logic [31:0] A, B;
   logic        read_hi;
   logic        id_md_use;
   logic        busy, stall_req;
   logic [31:0] HI, LO, md_out;

   int n_cmp  = 0;
   int n_fail = 0;

   md_scheduler #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
      .clk(clk), .reset(reset), .md_op(md_op), .ex_valid(ex_valid),
      .A(A), .B(B), .read_hi(read_hi), .id_md_use(id_md_use),
      .busy(busy), .stall_req(stall_req), .HI(HI), .LO(LO), .md_out(md_out)
   );

   always #5 clk = ~clk;

   always @(posedge clk)
      if (!reset && busy && ex_valid && md_op != 3'd0 && md_op != 3'd7)
         $error("md command issued while busy");

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      md_op = op; ex_valid = 1'b1; A = a; B = b;
   endtask

   task automatic idle_inputs();
      md_op = 3'd0; ex_valid = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; idle_inputs(); A = '0; B = '0; read_hi = 1'b0; id_md_use = 1'b0;
      #3;
      n_cmp++;
      if (busy !== 1'b0 || stall_req !== 1'b0 || HI !== 32'd0 || LO !== 32'd0 || md_out !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: busy=%b stall=%b HI=%h LO=%h md_out=%h, required all zero",
                  busy, stall_req, HI, LO, md_out);
      end
      step();
      reset = 1'b0;
      step();
   endtask

   task automatic test_mult();
      issue(3'd1, 32'hFFFFFFFD, 32'd7);
      #1;
      n_cmp++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_T: got %b required 0", busy); end
      for (int k = 1; k <= 5; k++) begin
         step();
         idle_inputs();
         n_cmp++;
         if (busy !== 1'b1 || HI !== 32'd0 || LO !== 32'd0) begin
            n_fail++;
            $display("FAIL mult_busy_T+%0d: busy=%b HI=%h LO=%h, required 1/0/0", k, busy, HI, LO);
         end
      end
      step();
      n_cmp++;
      if (busy !== 1'b0 || HI !== 32'hFFFFFFFF || LO !== 32'hFFFFFFEB) begin
         n_fail++;
         $display("FAIL mult_result: busy=%b HI=%h LO=%h, required 0/ffffffff/ffffffeb", busy, HI, LO);
      end
      read_hi = 1'b1; #1;
      n_cmp++;
      if (md_out !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL md_out_hi: got %h required ffffffff", md_out); end
      read_hi = 1'b0; #1;
      n_cmp++;
      if (md_out !== 32'hFFFFFFEB) begin n_fail++; $display("FAIL md_out_lo: got %h required ffffffeb", md_out); end
   endtask

   task automatic test_multu();
      step();
      issue(3'd2, 32'hFFFFFFFF, 32'd2);
      for (int k = 1; k <= 5; k++) begin
         step();
         idle_inputs();
         n_cmp++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL multu_busy_T+%0d: got %b required 1", k, busy); end
      end
      step();
      n_cmp++;
      if (busy !== 1'b0 || HI !== 32'h00000001 || LO !== 32'hFFFFFFFE) begin
         n_fail++;
         $display("FAIL multu_result: busy=%b HI=%h LO=%h, required 0/00000001/fffffffe", busy, HI, LO);
      end
   endtask

   task automatic test_div(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo, input string name);
      step();
      issue(op, a, b);
      for (int k = 1; k <= 10; k++) begin
         step();
         idle_inputs();
         n_cmp++;
         if (busy !== 1'b1) begin n_fail++; $display("FAIL %s_busy_T+%0d: got %b required 1", name, k, busy); end
      end
      step();
      n_cmp++;
      if (busy !== 1'b0 || HI !== exp_hi || LO !== exp_lo) begin
         n_fail++;
         $display("FAIL %s_result: busy=%b HI=%h LO=%h, required 0/%h/%h", name, busy, HI, LO, exp_hi, exp_lo);
      end
   endtask

   task automatic test_mthi_mtlo();
      step();
      issue(3'd6, 32'hDEAD0000, 32'h12345678);
      step();
      issue(3'd5, 32'h0000ABCD, 32'h55555555);
      n_cmp++;
      if (LO !== 32'h12345678 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mtlo: LO=%h busy=%b, required 12345678/0", LO, busy);
      end
      step();
      idle_inputs();
      n_cmp++;
      if (HI !== 32'h0000ABCD || LO !== 32'h12345678 || busy !== 1'b0) begin
         n_fail++; $display("FAIL mthi: HI=%h LO=%h busy=%b, required 0000abcd/12345678/0", HI, LO, busy);
      end
      // reserved op and a mult without ex_valid must both be ignored
      issue(3'd7, 32'h1, 32'h1);
      step();
      md_op = 3'd1; ex_valid = 1'b0;
      step();
      idle_inputs();
      n_cmp++;
      if (busy !== 1'b0 || HI !== 32'h0000ABCD || LO !== 32'h12345678) begin
         n_fail++; $display("FAIL ignored_ops: busy=%b HI=%h LO=%h, required 0/0000abcd/12345678", busy, HI, LO);
      end
   endtask

   task automatic test_stall();
      step();
      id_md_use = 1'b1;
      issue(3'd1, 32'd3, 32'd5);
      #1;
      n_cmp++;
      if (stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_T: got %b required 1", stall_req); end
      for (int k = 1; k <= 5; k++) begin
         step();
         idle_inputs();
         n_cmp++;
         if (stall_req !== 1'b1) begin n_fail++; $display("FAIL stall_T+%0d: got %b required 1", k, stall_req); end
      end
      step();
      n_cmp++;
      if (stall_req !== 1'b0 || LO !== 32'd15 || HI !== 32'd0) begin
         n_fail++; $display("FAIL stall_T+6: stall=%b HI=%h LO=%h, required 0/00000000/0000000f", stall_req, HI, LO);
      end
   endtask

   task automatic test_reset_mid_op();
      step();
      issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      step();
      idle_inputs();
      step();
      step();
      #1;
      reset = 1'b1;
      #1;
      n_cmp++;
      if (busy !== 1'b0 || stall_req !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_mid_op: busy=%b stall=%b HI=%h LO=%h, required 0/0/0/0", busy, stall_req, HI, LO);
      end
      @(negedge clk);
      reset = 1'b0;
      for (int k = 0; k < 8; k++) step();
      n_cmp++;
      if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin
         n_fail++; $display("FAIL no_commit_after_reset: busy=%b HI=%h LO=%h, required 0/0/0", busy, HI, LO);
      end
      id_md_use = 1'b0;
   endtask

   initial begin
      test_reset();
      test_mult();
      test_multu();
      test_div(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, "div");
      test_div(3'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, "divu");
      test_mthi_mtlo();
      test_div(3'd3, 32'h00000064, 32'd0, 32'h0000ABCD, 32'h12345678, "div_by_zero");
      test_stall();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
